// File: rtl/io_input_ctrl.sv
// io_input_ctrl: synchronises and debounces the data switches, index
// switches and confirm button, snapshots data/index on each confirm press
// and holds a sticky confirm flag until the CPU reads it with a7 == 0.
// Build option: define IO_DEBOUNCE_EN to build the counting debouncers;
// without it each stable register simply follows its synchroniser.

// io_debounce: 2-flop synchroniser followed by a whole-vector debouncer.
module io_debounce #(
  parameter int W               = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw,
  output logic [W-1:0] stable
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;

  // Two-flop synchroniser bringing the asynchronous input into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Count consecutive cycles where s2 is steady and differs from the stable
  // value. s1 is the value s2 takes next, so s1 != s2 marks an edge at which
  // s2 changes; clearing there restarts the count as the new value arrives,
  // which lands the stable update DEBOUNCE_CYCLES edges after s2 settles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= '0;
    end else if ((s1 != s2) || (s2 == stable)) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      stable <= s2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  localparam int unused_cfg = DEBOUNCE_CYCLES + CNT_W;

  // Without debouncing the stable register just retimes the synchroniser.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable <= '0;
    end else begin
      stable <= s2;
    end
  end
`endif

endmodule

// io_input_ctrl: top level conditioner feeding the CPU IO-read path.
module io_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  sw_data,
  input  logic [2:0]  sw_index,
  input  logic        btn_confirm,
  input  logic        io_read,
  input  logic [31:0] rega7,
  output logic [7:0]  io_rdata,
  output logic [2:0]  test_index,
  output logic        confirm_ctrl,
  output logic        confirm_pulse
);

  logic [7:0] data_stable;
  logic [2:0] index_stable;
  logic       btn_stable;
  logic       btn_stable_d;
  logic       confirm_read;

  io_debounce #(.W(8), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_data_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (sw_data),
    .stable (data_stable)
  );

  io_debounce #(.W(3), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_index_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (sw_index),
    .stable (index_stable)
  );

  io_debounce #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_btn_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (btn_confirm),
    .stable (btn_stable)
  );

  assign confirm_read = io_read && (rega7 == 32'd0);

  // Registered rising-edge detect on the debounced button; a held button
  // yields a single pulse and release produces nothing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_stable_d  <= 1'b0;
      confirm_pulse <= 1'b0;
    end else begin
      btn_stable_d  <= btn_stable;
      confirm_pulse <= btn_stable & ~btn_stable_d;
    end
  end

  // Snapshot the debounced switches on each press so the CPU sees the values
  // that matched the press, unaffected by later switch movement.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      io_rdata   <= '0;
      test_index <= '0;
    end else if (confirm_pulse) begin
      io_rdata   <= data_stable;
      test_index <= index_stable;
    end
  end

  // Sticky confirm flag: a press sets it, a confirm-service read clears it,
  // and a press coinciding with the clearing read wins so it is never lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      confirm_ctrl <= 1'b0;
    end else if (confirm_pulse) begin
      confirm_ctrl <= 1'b1;
    end else if (confirm_read) begin
      confirm_ctrl <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_input_ctrl.sv
// tb_io_input_ctrl: directed self-checking bench for io_input_ctrl.
// Latencies follow IO_DEBOUNCE_EN when it is defined for the build.
module tb_io_input_ctrl;

  localparam int D = 4;
`ifdef IO_DEBOUNCE_EN
  localparam int PL = D + 2;
  localparam int BOUNCE_PULSES = 1;
`else
  localparam int PL = 3;
  localparam int BOUNCE_PULSES = 3;
`endif
  localparam int FL = PL + 1;

  logic        clk;
  logic        rst_n;
  logic [7:0]  sw_data;
  logic [2:0]  sw_index;
  logic        btn_confirm;
  logic        io_read;
  logic [31:0] rega7;
  logic [7:0]  io_rdata;
  logic [2:0]  test_index;
  logic        confirm_ctrl;
  logic        confirm_pulse;

  int errors = 0;
  int checks = 0;

  io_input_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sw_data       (sw_data),
    .sw_index      (sw_index),
    .btn_confirm   (btn_confirm),
    .io_read       (io_read),
    .rega7         (rega7),
    .io_rdata      (io_rdata),
    .test_index    (test_index),
    .confirm_ctrl  (confirm_ctrl),
    .confirm_pulse (confirm_pulse)
  );

  // Free-running core clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, leaving time just past the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset with data and button active: outputs stay zero, then one press appears.
  task automatic test_reset();
    rst_n = 1'b0; sw_data = 8'hA5; sw_index = 3'd0; btn_confirm = 1'b1;
    io_read = 1'b0; rega7 = 32'd0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++;
      if ({io_rdata, test_index, confirm_ctrl, confirm_pulse} !== 13'd0) begin
        errors++;
        $display("[TB] FAIL reset_outputs cycle %0d: got rdata=%h idx=%0d ctrl=%b pulse=%b, want all 0",
                 i, io_rdata, test_index, confirm_ctrl, confirm_pulse);
      end
    end
    rst_n = 1'b1;
    step(1);
    for (int e = 1; e <= FL; e++) begin
      step(1);
      checks++;
      if (confirm_ctrl !== (e >= FL)) begin
        errors++;
        $display("[TB] FAIL reset_release_flag edge %0d: got %b, want %b", e, confirm_ctrl, (e >= FL));
      end
    end
    checks++;
    if (io_rdata !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL reset_release_data: got %h, want a5", io_rdata);
    end
  endtask

  // Non-zero service codes leave the flag; a7 == 0 clears it after the edge.
  task automatic test_read_clear();
    io_read = 1'b1; rega7 = 32'd2;
    step(1);
    checks++;
    if (confirm_ctrl !== 1'b1) begin
      errors++;
      $display("[TB] FAIL read_a7_2: got %b, want 1", confirm_ctrl);
    end
    rega7 = 32'h0001_0000;
    step(1);
    checks++;
    if (confirm_ctrl !== 1'b1) begin
      errors++;
      $display("[TB] FAIL read_a7_high: got %b, want 1", confirm_ctrl);
    end
    rega7 = 32'd0;
    #2;
    checks++;
    if (confirm_ctrl !== 1'b1) begin
      errors++;
      $display("[TB] FAIL read_clear_during: got %b, want 1", confirm_ctrl);
    end
    step(1);
    checks++;
    if (confirm_ctrl !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_clear_after: got %b, want 0", confirm_ctrl);
    end
    io_read = 1'b0;
  endtask

  // A held button yields no further pulses, and release yields no event.
  task automatic test_held_release();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (confirm_pulse === 1'b1) pulses++;
    end
    btn_confirm = 1'b0;
    for (int i = 0; i < 2 * FL + 2; i++) begin
      step(1);
      if (confirm_pulse === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("[TB] FAIL held_release_pulses: got %0d, want 0", pulses);
    end
    checks++;
    if (confirm_ctrl !== 1'b0) begin
      errors++;
      $display("[TB] FAIL held_release_flag: got %b, want 0", confirm_ctrl);
    end
  endtask

  // Clean press: one-cycle pulse, then flag and snapshot one edge later.
  task automatic test_clean_press();
    sw_data = 8'h3C; sw_index = 3'd5; btn_confirm = 1'b1;
    step(1);
    for (int e = 1; e <= FL + 1; e++) begin
      step(1);
      checks++;
      if (confirm_pulse !== (e == PL)) begin
        errors++;
        $display("[TB] FAIL clean_pulse edge %0d: got %b, want %b", e, confirm_pulse, (e == PL));
      end
      if (e == FL) begin
        checks++;
        if ({confirm_ctrl, io_rdata, test_index} !== {1'b1, 8'h3C, 3'd5}) begin
          errors++;
          $display("[TB] FAIL clean_snapshot: got ctrl=%b rdata=%h idx=%0d, want ctrl=1 rdata=3c idx=5",
                   confirm_ctrl, io_rdata, test_index);
        end
      end
    end
    btn_confirm = 1'b0;
    step(FL + 4);
  endtask

  // Bouncing button: only the final steady rise produces a press.
  task automatic test_bounce();
    logic [4:0] pattern;
    int pulses;
    int last_edge;
    io_read = 1'b1; rega7 = 32'd0;
    step(1);
    io_read = 1'b0;
    pattern = 5'b10101;
    pulses = 0;
    last_edge = -1;
    for (int t = 0; t < 30; t++) begin
      btn_confirm = (t < 5) ? pattern[t] : 1'b1;
      step(1);
      if (confirm_pulse === 1'b1) begin
        pulses++;
        last_edge = t;
      end
    end
    checks++;
    if (pulses != BOUNCE_PULSES) begin
      errors++;
      $display("[TB] FAIL bounce_count: got %0d, want %0d", pulses, BOUNCE_PULSES);
    end
    checks++;
    if (last_edge != 4 + PL) begin
      errors++;
      $display("[TB] FAIL bounce_timing: got edge %0d, want %0d", last_edge, 4 + PL);
    end
    checks++;
    if (confirm_ctrl !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bounce_flag: got %b, want 1", confirm_ctrl);
    end
    btn_confirm = 1'b0;
    step(FL + 4);
  endtask

  // Clearing read in the same cycle as a new pulse: set wins, snapshot updates.
  task automatic test_collision();
    sw_data = 8'h81; sw_index = 3'd2; btn_confirm = 1'b1;
    step(1);
    step(PL);
    checks++;
    if (confirm_pulse !== 1'b1) begin
      errors++;
      $display("[TB] FAIL collision_pulse: got %b, want 1", confirm_pulse);
    end
    io_read = 1'b1; rega7 = 32'd0;
    step(1);
    io_read = 1'b0;
    checks++;
    if ({confirm_ctrl, io_rdata, test_index} !== {1'b1, 8'h81, 3'd2}) begin
      errors++;
      $display("[TB] FAIL collision_result: got ctrl=%b rdata=%h idx=%0d, want ctrl=1 rdata=81 idx=2",
               confirm_ctrl, io_rdata, test_index);
    end
  endtask

  // Switch movement without a press leaves the snapshot untouched.
  task automatic test_snapshot_hold();
    sw_data = 8'hFF; sw_index = 3'd7;
    for (int i = 0; i < 20; i++) begin
      step(1);
      checks++;
      if ({io_rdata, test_index} !== {8'h81, 3'd2}) begin
        errors++;
        $display("[TB] FAIL snapshot_hold cycle %0d: got rdata=%h idx=%0d, want rdata=81 idx=2",
                 i, io_rdata, test_index);
      end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_read_clear();
    test_held_release();
    test_clean_press();
    test_bounce();
    test_collision();
    test_snapshot_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
